// File: rtl/timer_pkg.sv
// Shared types and Johnson-ring helpers for the time-pulse decoder.
// The ring helpers are sized by RING_W_DEF, so the decoder's RING_W must equal it.
package timer_pkg;
  localparam int NTP_DEF    = 12;
  localparam int RING_W_DEF = 5;
  localparam int MCT_W_DEF  = 16;

  typedef enum logic [1:0] {SYNC, RUN, HALT} tp_state_t;

  function automatic logic [RING_W_DEF-1:0] johnson_next(input logic [RING_W_DEF-1:0] s);
    return {s[RING_W_DEF-2:0], ~s[RING_W_DEF-1]};
  endfunction

  // Walks the full Johnson orbit from zero; anything not on it is illegal.
  function automatic logic johnson_legal(input logic [RING_W_DEF-1:0] s);
    logic [RING_W_DEF-1:0] c;
    logic ok;
    c  = '0;
    ok = 1'b0;
    for (int i = 0; i < 2*RING_W_DEF; i++) begin
      ok = ok | (s == c);
      c  = johnson_next(c);
    end
    return ok;
  endfunction
endpackage

// File: rtl/phs_edge_det.sv
// Synchronous rising-edge detector for the timer phase strobe.
module phs_edge_det (
  input  logic CLOCK,
  input  logic SIM_RST,
  input  logic d,
  output logic rise
);
  logic phs2_q;

  always_ff @(posedge CLOCK) begin
    if (SIM_RST) phs2_q <= 1'b0;
    else         phs2_q <= d;
  end

  assign rise = d & ~phs2_q;
endmodule

// File: rtl/timepulse_decoder.sv
// Derives the one-hot T01..T{NTP} train from the timer ring, shadows the ring
// to detect divergence, and counts completed memory cycles.
module timepulse_decoder
  import timer_pkg::*;
#(
  parameter int NTP    = NTP_DEF,
  parameter int RING_W = RING_W_DEF,
  parameter int MCT_W  = MCT_W_DEF
) (
  input  logic              CLOCK,
  input  logic              SIM_RST,
  input  logic              PHS2,
  input  logic [RING_W-1:0] RING,
  input  logic              STOP,
  input  logic              GOJAM,
  output logic [NTP-1:0]    T,
  output logic [3:0]        TPIDX,
  output logic              EOC,
  output logic [MCT_W-1:0]  MCT_CNT,
  output logic              RING_ALARM,
  output logic              SYNCED
);
  localparam logic [3:0] LAST = 4'(NTP-1);

  logic              adv;
  tp_state_t         state, state_nxt;
  logic [3:0]        tpidx, tpidx_nxt;
  logic [NTP-1:0]    t_q, t_nxt;
  logic [RING_W-1:0] shadow, shadow_nxt, exp_ring;
  logic              eoc, eoc_nxt, alarm, alarm_nxt, ring_ok;
  logic [MCT_W-1:0]  mct, mct_nxt;

  phs_edge_det u_edge (
    .CLOCK  (CLOCK),
    .SIM_RST(SIM_RST),
    .d      (PHS2),
    .rise   (adv)
  );

  always_ff @(posedge CLOCK) begin
    if (SIM_RST) state <= SYNC;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tpidx_nxt  = tpidx;
    shadow_nxt = shadow;
    eoc_nxt    = 1'b0;
    mct_nxt    = mct;
    alarm_nxt  = alarm;
    exp_ring   = johnson_next(shadow);
    ring_ok    = (RING == exp_ring) && johnson_legal(RING);
    if (GOJAM) begin
      state_nxt = SYNC;
      tpidx_nxt = LAST;
    end else begin
      unique case (state)
        SYNC: begin
          if (!STOP && adv && RING == '0) begin
            state_nxt  = RUN;
            tpidx_nxt  = 4'd0;
            shadow_nxt = '0;
          end
        end
        RUN, HALT: begin
          if (STOP) begin
            state_nxt = HALT;
          end else begin
            // Releasing HALT with a coincident edge treats that edge as a normal advance.
            state_nxt = RUN;
            if (adv) begin
              if (ring_ok) begin
                shadow_nxt = exp_ring;
                if (tpidx == LAST) begin
                  tpidx_nxt = 4'd0;
                  eoc_nxt   = 1'b1;
                  mct_nxt   = mct + MCT_W'(1);
                end else begin
                  tpidx_nxt = tpidx + 4'd1;
                end
              end else begin
                alarm_nxt = 1'b1;
                tpidx_nxt = LAST;
                state_nxt = SYNC;
              end
            end
          end
        end
        default: begin
          state_nxt = SYNC;
          tpidx_nxt = LAST;
        end
      endcase
    end
    t_nxt = {{(NTP-1){1'b0}}, 1'b1} << tpidx_nxt;
  end

  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      tpidx  <= LAST;
      t_q    <= {1'b1, {(NTP-1){1'b0}}};
      shadow <= '0;
      eoc    <= 1'b0;
      mct    <= '0;
      alarm  <= 1'b0;
    end else begin
      tpidx  <= tpidx_nxt;
      t_q    <= t_nxt;
      shadow <= shadow_nxt;
      eoc    <= eoc_nxt;
      mct    <= mct_nxt;
      alarm  <= alarm_nxt;
    end
  end

  assign T          = t_q;
  assign TPIDX      = tpidx;
  assign EOC        = eoc;
  assign MCT_CNT    = mct;
  assign RING_ALARM = alarm;
  assign SYNCED     = (state != SYNC);
endmodule
